// File: rtl/dcache_flush_pkg.sv
// Shared state encoding, default geometry and line-address helper for the
// data-cache flush walker.
package dcache_flush_pkg;

  typedef logic [2:0] walk_state_t;

  localparam walk_state_t ST_IDLE       = 3'd0;
  localparam walk_state_t ST_READ_META  = 3'd1;
  localparam walk_state_t ST_WAIT_META  = 3'd2;
  localparam walk_state_t ST_WRITEBACK  = 3'd3;
  localparam walk_state_t ST_INVALIDATE = 3'd4;
  localparam walk_state_t ST_DONE       = 3'd5;

  localparam int DEF_PLEN       = 56;
  localparam int DEF_NUM_SETS   = 256;
  localparam int DEF_NUM_WAYS   = 8;
  localparam int DEF_LINE_BYTES = 16;
  localparam int ADDR_CALC_W    = 128;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Line address {tag, set, zero offset}; caller truncates to PLEN.
  function automatic logic [ADDR_CALC_W-1:0] line_addr(
    input logic [ADDR_CALC_W-1:0] tag,
    input logic [ADDR_CALC_W-1:0] set,
    input int                     set_w,
    input int                     off_w
  );
    return (tag << (set_w + off_w)) | (set << off_w);
  endfunction

endpackage

// File: rtl/dcache_flush_walker_lzc_onehot.sv
// Lowest-set-bit finder: returns the one-hot of the lowest pending way,
// its index, and an empty flag.
module lzc_onehot #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             empty
);

  logic seen_s;

  // Scan upward; the first set bit wins and masks all higher ones.
  always_comb begin
    onehot = {WIDTH{1'b0}};
    idx    = {IDX_W{1'b0}};
    seen_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = mask[i] & ~seen_s;
      idx       = onehot[i] ? IDX_W'(i) : idx;
      seen_s    = seen_s | mask[i];
    end
    empty = ~seen_s;
  end

endmodule

// File: rtl/dcache_flush_walker.sv
// Walks every dcache set on a flush request, writes back valid+dirty lines,
// invalidates each set and acknowledges the controller when done.
module dcache_flush_walker
  import dcache_flush_pkg::*;
#(
  parameter int PLEN       = DEF_PLEN,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int TAG_W      = PLEN - $clog2(NUM_SETS) - $clog2(LINE_BYTES)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  output logic                      flush_ack_o,
  output logic                      busy_o,
  output logic                      meta_req_o,
  input  logic                      meta_gnt_i,
  output logic [$clog2(NUM_SETS)-1:0] meta_set_o,
  input  logic                      meta_rvalid_i,
  input  logic [NUM_WAYS-1:0]       meta_valid_i,
  input  logic [NUM_WAYS-1:0]       meta_dirty_i,
  input  logic [NUM_WAYS*TAG_W-1:0] meta_tag_i,
  output logic                      wb_req_o,
  input  logic                      wb_gnt_i,
  output logic [PLEN-1:0]           wb_addr_o,
  output logic                      inv_we_o
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int WAY_W = idx_width(NUM_WAYS);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

  walk_state_t               state_r;
  logic [SET_W-1:0]          set_r;
  logic [NUM_WAYS-1:0]       mask_r;
  logic [NUM_WAYS*TAG_W-1:0] tags_r;

  logic [NUM_WAYS-1:0] sel_onehot_s;
  logic [WAY_W-1:0]    sel_idx_s;
  logic                sel_empty_s;
  logic [NUM_WAYS-1:0] mask_after_s;
  logic [NUM_WAYS-1:0] pending_s;
  logic [TAG_W-1:0]    sel_tag_s;

  lzc_onehot #(
    .WIDTH (NUM_WAYS),
    .IDX_W (WAY_W)
  ) u_lzc (
    .mask   (mask_r),
    .onehot (sel_onehot_s),
    .idx    (sel_idx_s),
    .empty  (sel_empty_s)
  );

  assign pending_s    = meta_valid_i & meta_dirty_i;
  assign mask_after_s = mask_r & ~sel_onehot_s;

  // Tag of the way currently being written back.
  always_comb begin
    sel_tag_s = {TAG_W{1'b0}};
    for (int w = 0; w < NUM_WAYS; w++) begin
      sel_tag_s = (WAY_W'(w) == sel_idx_s) ? tags_r[w*TAG_W +: TAG_W] : sel_tag_s;
    end
  end

  // Walk sequencer: state, set counter, pending-way mask and captured tags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      set_r   <= {SET_W{1'b0}};
      mask_r  <= {NUM_WAYS{1'b0}};
      tags_r  <= {(NUM_WAYS*TAG_W){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (flush_i) begin
            set_r   <= {SET_W{1'b0}};
            state_r <= ST_READ_META;
          end
        end
        ST_READ_META: begin
          if (meta_gnt_i) state_r <= ST_WAIT_META;
        end
        ST_WAIT_META: begin
          if (meta_rvalid_i) begin
            mask_r  <= pending_s;
            tags_r  <= meta_tag_i;
            state_r <= (|pending_s) ? ST_WRITEBACK : ST_INVALIDATE;
          end
        end
        ST_WRITEBACK: begin
          // An empty mask here is unreachable but must never stall the walk.
          if (sel_empty_s) begin
            state_r <= ST_INVALIDATE;
          end else if (wb_gnt_i) begin
            mask_r <= mask_after_s;
            if (~|mask_after_s) state_r <= ST_INVALIDATE;
          end
        end
        ST_INVALIDATE: begin
          if (set_r == LAST_SET) begin
            state_r <= ST_DONE;
          end else begin
            set_r   <= set_r + SET_ONE;
            state_r <= ST_READ_META;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_r != ST_IDLE);
  assign meta_req_o  = (state_r == ST_READ_META);
  assign meta_set_o  = set_r;
  assign wb_req_o    = (state_r == ST_WRITEBACK) & ~sel_empty_s;
  assign inv_we_o    = (state_r == ST_INVALIDATE);
  assign flush_ack_o = (state_r == ST_DONE);
  assign wb_addr_o   = wb_req_o
                     ? PLEN'(line_addr(ADDR_CALC_W'(sel_tag_s), ADDR_CALC_W'(set_r), SET_W, OFF_W))
                     : {PLEN{1'b0}};

endmodule
